load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access encodings, FSM states and the
// default data-memory depth.
package lsu_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 100;

  typedef enum logic [2:0] {
    OpLb  = 3'd0,
    OpLh  = 3'd1,
    OpLw  = 3'd2,
    OpLbu = 3'd3,
    OpLhu = 3'd4,
    OpSb  = 3'd5,
    OpSh  = 3'd6,
    OpSw  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

  function automatic logic is_store(input lsu_op_e op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    logic mis;
    case (op)
      OpLh, OpLhu, OpSh: mis = off[0];
      OpLw, OpSw:        mis = (off != 2'b00);
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges byte/halfword store data into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  lsu_op_e     w_op;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_op   = lsu_op_e'(i_op);
  assign w_half = i_off[1] ? i_rd_word[31:16] : i_rd_word[15:0];

  always_comb begin
    w_byte = i_rd_word[7:0];
    case (i_off)
      2'd0:    w_byte = i_rd_word[7:0];
      2'd1:    w_byte = i_rd_word[15:8];
      2'd2:    w_byte = i_rd_word[23:16];
      default: w_byte = i_rd_word[31:24];
    endcase
  end

  always_comb begin
    o_load_data = i_rd_word;
    case (w_op)
      OpLb:    o_load_data = {{24{w_byte[7]}}, w_byte};
      OpLbu:   o_load_data = {24'h0, w_byte};
      OpLh:    o_load_data = {{16{w_half[15]}}, w_half};
      OpLhu:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_rd_word;
    endcase
  end

  // Only the addressed lane is replaced; everything else comes from the read.
  always_comb begin
    o_store_word = i_rd_word;
    case (w_op)
      OpSb: begin
        case (i_off)
          2'd0:    o_store_word[7:0]   = i_wdata[7:0];
          2'd1:    o_store_word[15:8]  = i_wdata[7:0];
          2'd2:    o_store_word[23:16] = i_wdata[7:0];
          default: o_store_word[31:24] = i_wdata[7:0];
        endcase
      end
      OpSh: begin
        if (i_off[1]) o_store_word[31:16] = i_wdata[15:0];
        else          o_store_word[15:0]  = i_wdata[15:0];
      end
      OpSw:    o_store_word = i_wdata;
      default: o_store_word = i_rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one CPU access at a time against a word-addressed data memory,
// with read-modify-write for byte/halfword stores and misalignment rejection.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  lsu_state_e  r_state;
  lsu_op_e     r_op;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;
  logic        r_we;
  logic        r_busy;
  logic        r_done;
  logic        r_mis;

  lsu_op_e     w_op;
  logic        w_mis;
  logic [31:0] w_idx;
  logic [31:0] w_load;
  logic [31:0] w_store;

  assign w_op  = lsu_op_e'(op);
  assign w_mis = is_misaligned(w_op, addr[1:0]);
  assign w_idx = {2'b00, addr[31:2]} % MEM_WORDS;

  lsu_align u_align (
    .i_op         (r_op),
    .i_off        (r_off),
    .i_rd_word    (mem_RD),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load),
    .o_store_word (w_store)
  );

  // Outputs are registered and set on the edge that enters the relevant state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_op     <= OpLb;
      r_off    <= 2'b00;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_mem_a  <= 32'h0;
      r_mem_wd <= 32'h0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mis    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (req) begin
            r_op    <= w_op;
            r_off   <= addr[1:0];
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            if (w_mis) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_mis   <= 1'b1;
            end else begin
              r_mem_a <= w_idx;
              if (w_op == OpSw) begin
                r_state  <= StWr;
                r_we     <= 1'b1;
                r_mem_wd <= wdata;
              end else begin
                r_state <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (is_store(r_op)) begin
            r_state  <= StWr;
            r_we     <= 1'b1;
            r_mem_wd <= w_store;
          end else begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_rdata <= w_load;
          end
        end
        StWr: begin
          r_state <= StDone;
          r_done  <= 1'b1;
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign misaligned = r_mis;
  assign mem_A      = r_mem_a;
  assign mem_WD     = r_mem_wd;
  assign mem_WE     = r_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 100-word behavioural data memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misaligned, mem_WE;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;

  logic [31:0] mem [0:99];
  logic        tb_we = 1'b0;
  logic [6:0]  tb_idx = 7'd0;
  logic [31:0] tb_wd = 32'h0;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  int lat, we_cnt, n_done, n_we, first_done, last_done, gap_bad;
  logic [31:0] wd_seen, a_seen;
  logic        mis_seen;

  always #5 CLK = ~CLK;

  load_store_unit #(.MEM_WORDS(100)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .req        (req),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  assign mem_RD = (mem_A < 32'd100) ? mem[mem_A[6:0]] : 32'h0;

  always @(posedge CLK) begin
    if (mem_WE && mem_A < 32'd100) mem[mem_A[6:0]] <= mem_WD;
    else if (tb_we) mem[tb_idx] <= tb_wd;
  end

  always @(negedge CLK) if (misaligned && !done) viol++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge CLK);
    tb_we = 1'b1; tb_idx = 7'(idx); tb_wd = data;
    @(posedge CLK); #1;
    tb_we = 1'b0;
  endtask

  // lat counts cycles from the request cycle to the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
    @(negedge CLK);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge CLK); #1;
    req = 1'b0;
    lat = 1; we_cnt = 0; wd_seen = 32'h0; a_seen = 32'h0;
    if (mem_WE) begin we_cnt++; wd_seen = mem_WD; a_seen = mem_A; end
    while (!done && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
      if (mem_WE) begin we_cnt++; wd_seen = mem_WD; a_seen = mem_A; end
    end
    mis_seen = misaligned;
    @(posedge CLK); #1;
  endtask

  initial begin
    preload(3, 32'h8899AABB);
    preload(5, 32'h11223344);
    #1;
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_mis", {31'h0, misaligned}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_we", {31'h0, mem_WE}, 32'h0);
    check_eq("rst_mem_a", mem_A, 32'h0);
    check_eq("rst_mem_wd", mem_WD, 32'h0);
    @(negedge CLK); reset = 1'b1;

    run_op(3'd0, 32'h0D, 32'h0);
    check_eq("lb_rdata", rdata, 32'hFFFFFFAA);
    check_eq("lb_lat", lat, 2);
    check_eq("lb_we", we_cnt, 0);
    check_eq("lb_mis", {31'h0, mis_seen}, 32'h0);
    run_op(3'd3, 32'h0D, 32'h0);
    check_eq("lbu_rdata", rdata, 32'h000000AA);
    run_op(3'd1, 32'h0E, 32'h0);
    check_eq("lh_rdata", rdata, 32'hFFFF8899);
    run_op(3'd4, 32'h0C, 32'h0);
    check_eq("lhu_rdata", rdata, 32'h0000AABB);
    run_op(3'd2, 32'h0C, 32'h0);
    check_eq("lw_rdata", rdata, 32'h8899AABB);

    run_op(3'd6, 32'h0E, 32'h00001234);
    check_eq("sh_lat", lat, 3);
    check_eq("sh_we", we_cnt, 1);
    check_eq("sh_wd", wd_seen, 32'h1234AABB);
    check_eq("sh_mem", mem[3], 32'h1234AABB);
    check_eq("sh_rdata_held", rdata, 32'h8899AABB);
    run_op(3'd5, 32'h0D, 32'hFFFFFF55);
    check_eq("sb_lat", lat, 3);
    check_eq("sb_mem", mem[3], 32'h123455BB);

    run_op(3'd7, 32'h10, 32'hDEADBEEF);
    check_eq("sw_lat", lat, 2);
    check_eq("sw_we", we_cnt, 1);
    check_eq("sw_addr", a_seen, 32'd4);
    check_eq("sw_wd", wd_seen, 32'hDEADBEEF);
    check_eq("sw_mem", mem[4], 32'hDEADBEEF);

    run_op(3'd2, 32'h06, 32'h0);
    check_eq("mis_lat", lat, 1);
    check_eq("mis_flag", {31'h0, mis_seen}, 32'h1);
    check_eq("mis_we", we_cnt, 0);
    check_eq("mis_rdata", rdata, 32'h8899AABB);
    run_op(3'd6, 32'h0F, 32'h0);
    check_eq("sh_mis_flag", {31'h0, mis_seen}, 32'h1);
    check_eq("sh_mis_we", we_cnt, 0);

    run_op(3'd2, 32'h1A0, 32'h0);
    check_eq("wrap_rdata", rdata, 32'hDEADBEEF);

    // Second request while busy must be dropped.
    @(negedge CLK); req = 1'b1; op = 3'd2; addr = 32'h0C; wdata = 32'h0;
    @(posedge CLK); #1; req = 1'b0;
    @(negedge CLK); req = 1'b1; op = 3'd7; addr = 32'h10; wdata = 32'h0;
    @(posedge CLK); #1; req = 1'b0;
    check_eq("busy_done", {31'h0, done}, 32'h1);
    n_done = 0; n_we = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (done) n_done++;
      if (mem_WE) n_we++;
    end
    check_eq("busy_extra_done", n_done, 0);
    check_eq("busy_extra_we", n_we, 0);
    check_eq("busy_mem4", mem[4], 32'hDEADBEEF);
    check_eq("busy_rdata", rdata, 32'h123455BB);

    // Reset during the write phase of a byte store.
    @(negedge CLK); req = 1'b1; op = 3'd5; addr = 32'h14; wdata = 32'h000000AA;
    @(posedge CLK); #1; req = 1'b0;
    @(posedge CLK); #1;
    check_eq("rmw_we_before", {31'h0, mem_WE}, 32'h1);
    reset = 1'b0;
    #1;
    check_eq("abort_we", {31'h0, mem_WE}, 32'h0);
    check_eq("abort_busy", {31'h0, busy}, 32'h0);
    check_eq("abort_rdata", rdata, 32'h0);
    n_done = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      if (done) n_done++;
    end
    @(negedge CLK); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (done) n_done++;
    end
    check_eq("abort_no_done", n_done, 0);
    check_eq("abort_mem5", mem[5], 32'h11223344);

    // Held request: back-to-back LW every 3 cycles.
    @(negedge CLK); req = 1'b1; op = 3'd2; addr = 32'h0C; wdata = 32'h0;
    n_done = 0; first_done = -1; last_done = -1; gap_bad = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge CLK); #1;
      if (done) begin
        if (last_done >= 0 && cyc - last_done != 3) gap_bad++;
        if (first_done < 0) first_done = cyc;
        last_done = cyc;
        n_done++;
      end
    end
    req = 1'b0;
    check_eq("b2b_count", n_done, 4);
    check_eq("b2b_first", first_done, 2);
    check_eq("b2b_gap", gap_bad, 0);
    check_eq("b2b_rdata", rdata, 32'h123455BB);
    @(posedge CLK); #1;
    check_eq("b2b_idle", {31'h0, busy}, 32'h0);

    check_eq("mis_without_done", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
